// File: rtl/pic_bus_master.sv
// CPU-side bus initiator for the 8259A PIC: turns single-beat requests into timed cs_n/a0/rd_n/wr_n cycles.
// Optional interrupt-acknowledge sequence (req_inta/inta_n) is enabled by defining PIC_INTA_CYCLE_EN.
module pic_bus_master #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned PULSE_CYCLES    = 2,
    parameter int unsigned HOLD_CYCLES     = 1,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_a0,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       cs_n,
    output logic       a0,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
`ifdef PIC_INTA_CYCLE_EN
    ,
    input  logic       req_inta,
    output logic       inta_n
`endif
);

    localparam int unsigned MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_HR = (HOLD_CYCLES > RECOVERY_CYCLES) ? HOLD_CYCLES : RECOVERY_CYCLES;
    localparam int unsigned MAXC   = (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
    localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_PULSE   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LD_HOLD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LD_RECOVER = CW'(RECOVERY_CYCLES - 1);

    if (SETUP_CYCLES == 0 || PULSE_CYCLES == 0 || HOLD_CYCLES == 0 || RECOVERY_CYCLES == 0) begin : g_param_check
        $error("pic_bus_master: all cycle-count parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_RECOVER,
        ST_INTA1,
        ST_IGAP,
        ST_INTA2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_load;
    logic            w_done;
    logic            w_capture;
    logic            w_bus_active;
    logic            r_write;
    logic            r_a0;
    logic [7:0]      r_wdata;
    logic            r_rsp_valid;
    logic [7:0]      r_rdata;
`ifdef PIC_INTA_CYCLE_EN
    logic            r_inta;
`endif

    assign w_done = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = '0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_load  = LD_SETUP;
`ifdef PIC_INTA_CYCLE_EN
                    if (req_inta) begin
                        w_state_nxt = ST_INTA1;
                        w_cnt_load  = LD_PULSE;
                    end
`endif
                end
            end
            ST_SETUP: begin
                if (w_done) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_load  = LD_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_done) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_load  = LD_HOLD;
                    w_capture   = ~r_write;
                end
            end
            ST_HOLD: begin
                if (w_done) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_load  = LD_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef PIC_INTA_CYCLE_EN
            ST_INTA1: begin
                if (w_done) begin
                    w_state_nxt = ST_IGAP;
                    w_cnt_load  = LD_RECOVER;
                end
            end
            ST_IGAP: begin
                if (w_done) begin
                    w_state_nxt = ST_INTA2;
                    w_cnt_load  = LD_PULSE;
                end
            end
            ST_INTA2: begin
                // The vector is taken at the end of the second pulse; rsp_valid follows in RECOVER.
                if (w_done) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_load  = LD_RECOVER;
                    w_capture   = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write <= 1'b0;
            r_a0    <= 1'b0;
            r_wdata <= '0;
`ifdef PIC_INTA_CYCLE_EN
            r_inta  <= 1'b0;
`endif
        end else if (r_state == ST_IDLE && req_valid) begin
            r_a0    <= req_a0;
            r_wdata <= req_wdata;
`ifdef PIC_INTA_CYCLE_EN
            r_inta  <= req_inta;
            r_write <= req_write & ~req_inta;
`else
            r_write <= req_write;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= w_capture;
            if (w_capture) begin
                r_rdata <= data_in;
            end
        end
    end

    assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_PULSE) || (r_state == ST_HOLD);

    assign req_ready = (r_state == ST_IDLE);
    assign cs_n      = ~w_bus_active;
    assign a0        = r_a0;
    assign rd_n      = ~((r_state == ST_PULSE) && ~r_write);
    assign wr_n      = ~((r_state == ST_PULSE) && r_write);
    assign data_oe   = w_bus_active && r_write;
    assign data_out  = data_oe ? r_wdata : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
`ifdef PIC_INTA_CYCLE_EN
    assign inta_n    = ~(((r_state == ST_INTA1) || (r_state == ST_INTA2)) && r_inta);
`endif

endmodule

// File: tb/tb_pic_bus_master.sv
// Directed bench for pic_bus_master: default-timing instance (A) and PULSE=4/HOLD=3 instance (B).
// Defining PIC_INTA_CYCLE_EN also exercises the interrupt-acknowledge sequence on instance A.
module tb_pic_bus_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_write, req_a0;
    logic [7:0] req_wdata;
    logic       sel_b;
    logic [7:0] tb_bus, tb_bus_late;
`ifdef PIC_INTA_CYCLE_EN
    logic       req_inta;
`endif

    logic       req_ready_a, rsp_valid_a, cs_n_a, a0_a, rd_n_a, wr_n_a, data_oe_a, w_inta_n_a;
    logic [7:0] rsp_rdata_a, data_out_a, data_in_a;
    logic       req_ready_b, rsp_valid_b, cs_n_b, a0_b, rd_n_b, wr_n_b, data_oe_b;
    logic [7:0] rsp_rdata_b, data_out_b, data_in_b;

    int n_vec = 0;
    int n_err = 0;
    int m_wait, m_occ, m_cs_low, m_wr_low, m_rd_low, m_oe, m_dbad, m_a0bad, m_rspv;
    logic [15:0] m_iseq;

    always #5 clk = ~clk;

    assign data_in_a = (!rd_n_a || !w_inta_n_a) ? tb_bus : 8'hFF;
    assign data_in_b = (!rd_n_b) ? tb_bus : 8'hFF;

    pic_bus_master u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid & ~sel_b),
        .req_ready (req_ready_a),
        .req_write (req_write),
        .req_a0    (req_a0),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_a),
        .rsp_rdata (rsp_rdata_a),
        .cs_n      (cs_n_a),
        .a0        (a0_a),
        .rd_n      (rd_n_a),
        .wr_n      (wr_n_a),
        .data_out  (data_out_a),
        .data_oe   (data_oe_a),
        .data_in   (data_in_a)
`ifdef PIC_INTA_CYCLE_EN
        ,
        .req_inta  (req_inta),
        .inta_n    (w_inta_n_a)
`endif
    );
`ifndef PIC_INTA_CYCLE_EN
    assign w_inta_n_a = 1'b1;
`endif

    pic_bus_master #(.PULSE_CYCLES(4), .HOLD_CYCLES(3)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid & sel_b),
        .req_ready (req_ready_b),
        .req_write (req_write),
        .req_a0    (req_a0),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_b),
        .rsp_rdata (rsp_rdata_b),
        .cs_n      (cs_n_b),
        .a0        (a0_b),
        .rd_n      (rd_n_b),
        .wr_n      (wr_n_b),
        .data_out  (data_out_b),
        .data_oe   (data_oe_b),
        .data_in   (data_in_b)
    );

    logic       s_ready, s_rspv, s_cs_n, s_a0, s_rd_n, s_wr_n, s_oe;
    logic [7:0] s_rdata, s_dout;
    assign s_ready = sel_b ? req_ready_b : req_ready_a;
    assign s_rspv  = sel_b ? rsp_valid_b : rsp_valid_a;
    assign s_cs_n  = sel_b ? cs_n_b      : cs_n_a;
    assign s_a0    = sel_b ? a0_b        : a0_a;
    assign s_rd_n  = sel_b ? rd_n_b      : rd_n_a;
    assign s_wr_n  = sel_b ? wr_n_b      : wr_n_a;
    assign s_oe    = sel_b ? data_oe_b   : data_oe_a;
    assign s_rdata = sel_b ? rsp_rdata_b : rsp_rdata_a;
    assign s_dout  = sel_b ? data_out_b  : data_out_a;

    function automatic logic inv_ok(input logic rd, input logic wr, input logic cs, input logic oe);
        return (rd | wr) & ~(oe & ~rd) & ~(cs & ~(rd & wr));
    endfunction

    // Bus-protocol invariants on both instances, every cycle.
    always @(negedge clk) begin
        n_vec++;
        assert (inv_ok(rd_n_a, wr_n_a, cs_n_a, data_oe_a) === 1'b1) else begin
            n_err++;
            $error("FAIL bus_invariant_a observed rd_n=%b wr_n=%b cs_n=%b oe=%b expected legal combination",
                   rd_n_a, wr_n_a, cs_n_a, data_oe_a);
        end
        n_vec++;
        assert (inv_ok(rd_n_b, wr_n_b, cs_n_b, data_oe_b) === 1'b1) else begin
            n_err++;
            $error("FAIL bus_invariant_b observed rd_n=%b wr_n=%b cs_n=%b oe=%b expected legal combination",
                   rd_n_b, wr_n_b, cs_n_b, data_oe_b);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic wr, input logic av, input logic [7:0] wd);
        m_wait = 0; m_occ = 0; m_cs_low = 0; m_wr_low = 0; m_rd_low = 0;
        m_oe = 0; m_dbad = 0; m_a0bad = 0; m_rspv = 0; m_iseq = '1;
        req_write = wr; req_a0 = av; req_wdata = wd; req_valid = 1'b1;
        while (s_ready !== 1'b1 && m_wait < 50) begin
            tick();
            m_wait++;
        end
        tick();
        req_valid = 1'b0;
        while (s_ready !== 1'b1 && m_occ < 100) begin
            if (!s_cs_n) m_cs_low++;
            if (!s_wr_n) m_wr_low++;
            if (!s_rd_n) m_rd_low++;
            if (s_oe) m_oe++;
            if (s_oe && s_dout !== wd) m_dbad++;
            if (!s_cs_n && s_a0 !== av) m_a0bad++;
            if (s_rspv) m_rspv++;
            m_iseq = {m_iseq[14:0], w_inta_n_a};
            if (m_occ == 3) tb_bus = tb_bus_late;
            tick();
            m_occ++;
        end
    endtask

    initial begin
        int n;
        int gap_cs;
        int bad;
        logic       rw, ra;
        logic [7:0] rd8, bus8;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_a0 = 1'b0; req_wdata = '0;
        sel_b = 1'b0; tb_bus = 8'h00; tb_bus_late = 8'h00;
`ifdef PIC_INTA_CYCLE_EN
        req_inta = 1'b0;
`endif
        tick(); tick();
        chk("rst_cs_n", int'(cs_n_a), 1);
        chk("rst_strobes", int'({rd_n_a, wr_n_a}), 3);
        chk("rst_oe_dout", int'({data_oe_a, data_out_a}), 0);
        chk("rst_ready", int'(req_ready_a), 1);
        chk("rst_rsp", int'({rsp_valid_a, rsp_rdata_a, a0_a}), 0);
        reset = 1'b0;
        tick();

        // ICW1 write on the default-timing instance.
        tb_bus = 8'hFF; tb_bus_late = 8'hFF;
        run_txn(1'b1, 1'b0, 8'h13);
        chk("wr_occupancy", m_occ, 6);
        chk("wr_cs_low", m_cs_low, 4);
        chk("wr_wr_low", m_wr_low, 2);
        chk("wr_rd_low", m_rd_low, 0);
        chk("wr_oe_cycles", m_oe, 4);
        chk("wr_data_bad", m_dbad, 0);
        chk("wr_a0_bad", m_a0bad, 0);
        chk("wr_rsp_valid", m_rspv, 0);

        // Status read, A0=1; the bus only carries 0xCD while rd_n is low.
        tb_bus = 8'hCD; tb_bus_late = 8'hCD;
        run_txn(1'b0, 1'b1, 8'h00);
        chk("rd_occupancy", m_occ, 6);
        chk("rd_rd_low", m_rd_low, 2);
        chk("rd_wr_low", m_wr_low, 0);
        chk("rd_oe_cycles", m_oe, 0);
        chk("rd_rsp_valid", m_rspv, 1);
        chk("rd_a0_bad", m_a0bad, 0);
        chk("rd_rdata", int'(rsp_rdata_a), 'hCD);

        // Back-to-back: write 0xAB then read, request held valid throughout.
        req_write = 1'b1; req_a0 = 1'b0; req_wdata = 8'hAB; req_valid = 1'b1;
        tb_bus = 8'h3C; tb_bus_late = 8'h3C;
        tick();
        req_write = 1'b0; req_a0 = 1'b1;
        n = 0; gap_cs = 0; bad = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            if (s_cs_n) gap_cs++;
            if (s_oe && s_dout !== 8'hAB) bad++;
            tick();
            n++;
        end
        chk("b2b_ready_return", n, 6);
        chk("b2b_cs_high_recover", gap_cs, 2);
        chk("b2b_first_data_bad", bad, 0);
        tick();
        chk("b2b_second_accept_cs", int'(s_cs_n), 0);
        chk("b2b_second_is_read", int'({s_oe, s_a0}), 1);
        req_valid = 1'b0;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_read_rdata", int'(rsp_rdata_a), 'h3C);

        // Reset asserted while the read strobe is low.
        tb_bus = 8'h77;
        req_write = 1'b0; req_a0 = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("midrst_in_pulse", int'(rd_n_a), 0);
        reset = 1'b1;
        #1;
        chk("midrst_cs_strobes", int'({cs_n_a, rd_n_a, wr_n_a}), 7);
        chk("midrst_oe_a0", int'({data_oe_a, a0_a, data_out_a}), 0);
        chk("midrst_ready", int'(req_ready_a), 1);
        chk("midrst_rdata", int'({rsp_valid_a, rsp_rdata_a}), 0);
        #2;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid_a) bad++;
        end
        chk("midrst_no_rsp", bad, 0);

        // Stretched-timing instance.
        sel_b = 1'b1;
        tb_bus = 8'hFF; tb_bus_late = 8'hFF;
        run_txn(1'b1, 1'b1, 8'h5A);
        chk("b_wr_occupancy", m_occ, 10);
        chk("b_wr_wr_low", m_wr_low, 4);
        chk("b_wr_cs_low", m_cs_low, 8);
        chk("b_wr_data_bad", m_dbad, 0);

        for (int i = 0; i < 100; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 1'($urandom_range(0, 1));
            rd8  = 8'($urandom_range(0, 255));
            bus8 = 8'($urandom_range(0, 255));
            tb_bus = bus8; tb_bus_late = bus8;
            run_txn(rw, ra, rd8);
            chk("b_rand_occupancy", m_occ, 10);
            chk("b_rand_a0_bad", m_a0bad, 0);
            if (rw) begin
                chk("b_rand_wr_low", m_wr_low, 4);
                chk("b_rand_data_bad", m_dbad, 0);
            end else begin
                chk("b_rand_rd_low", m_rd_low, 4);
                chk("b_rand_rsp_valid", m_rspv, 1);
                chk("b_rand_rdata", int'(rsp_rdata_b), int'(bus8));
            end
        end
        sel_b = 1'b0;

`ifdef PIC_INTA_CYCLE_EN
        // INTA with req_write also set: inta must win. First pulse carries 0xEE, second 0x48.
        req_inta = 1'b1;
        tb_bus = 8'hEE; tb_bus_late = 8'h48;
        run_txn(1'b1, 1'b0, 8'h99);
        req_inta = 1'b0;
        chk("inta_occupancy", m_occ, 8);
        chk("inta_pulse_pattern", int'(m_iseq[7:0]), 'h33);
        chk("inta_cs_low", m_cs_low, 0);
        chk("inta_strobes_low", m_wr_low + m_rd_low, 0);
        chk("inta_oe_cycles", m_oe, 0);
        chk("inta_rsp_valid", m_rspv, 1);
        chk("inta_vector", int'(rsp_rdata_a), 'h48);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
